roll_sequencer: RTL and testbench

- Sequences one dice roll across the six display controllers, replacing the free-running roll enable with a timed, staggered sequence.
- Debounces the raw roll button and drives a per-digit spin enable bus (one bit per display controller).
- Spins the selected digits, then settles them one at a time, lowest index first, and drives the LED chaser animation.
- Sits between the board button/switches and the DisplayController instances. Runs entirely on the 50 MHz clk and derives its own tick.

---
 rtl/roll_sequencer_if.sv | 21 ++
 rtl/roll_sequencer.sv | 136 +++++++++++++
 tb/tb_roll_sequencer.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/roll_sequencer_if.sv
// Board-side signal bundle for the roll sequencer: button/switch inputs and
// the enable, chaser and status outputs toward the display controllers.
interface roll_sequencer_if;
  logic       button;
  logic [5:0] dice_sel;
  logic [5:0] en;
  logic [9:0] LED;
  logic       busy;
  logic       done;
  logic [7:0] roll_count;

  modport master (
    output button, dice_sel,
    input  en, LED, busy, done, roll_count
  );

  modport slave (
    input  button, dice_sel,
    output en, LED, busy, done, roll_count
  );
endinterface

// File: rtl/roll_sequencer.sv
// Debounces the roll button and runs one timed roll: all selected digits spin,
// then settle lowest index first while the LED chaser rotates once per tick.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for a debounced press with a non-empty dice_sel
// S_SPIN   | all selected digits spinning for SPIN_TICKS ticks
// S_SETTLE | one digit settles every STAGGER_TICKS ticks
// S_DONE   | one clk: done pulse, roll_count bump, LED all on
module roll_sequencer #(
  parameter int TICK_DIV        = 10_000_000,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int SPIN_TICKS      = 10,
  parameter int STAGGER_TICKS   = 3
) (
  input logic             clk,
  input logic             resetButton,
  roll_sequencer_if.slave bus
);
  localparam int TW = $clog2(TICK_DIV);
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SW = (SPIN_TICKS > 1) ? $clog2(SPIN_TICKS) : 1;
  localparam int GW = (STAGGER_TICKS > 1) ? $clog2(STAGGER_TICKS) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] SPIN_LAST = SW'(SPIN_TICKS - 1);
  localparam logic [GW-1:0] STAG_LAST = GW'(STAGGER_TICKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SPIN, S_SETTLE, S_DONE} state_t;

  state_t        r_state;
  logic          r_sync1, r_sync2;
  logic          r_deb, r_deb_q, r_press;
  logic [DW-1:0] r_deb_cnt;
  logic [TW-1:0] r_tick_cnt;
  logic [SW-1:0] r_spin_cnt;
  logic [GW-1:0] r_stag_cnt;
  logic [5:0]    r_en;
  logic [9:0]    r_led;
  logic          r_busy, r_done;
  logic [7:0]    r_roll_count;
  logic          w_tick;

  assign w_tick = (r_tick_cnt == TICK_LAST);

  // Counter tracks consecutive synchronized samples that disagree with r_deb.
  always_ff @(posedge clk or negedge resetButton) begin
    if (!resetButton) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_deb     <= 1'b1;
      r_deb_q   <= 1'b1;
      r_press   <= 1'b0;
      r_deb_cnt <= '0;
    end else begin
      r_sync1 <= bus.button;
      r_sync2 <= r_sync1;
      r_deb_q <= r_deb;
      r_press <= r_deb_q & ~r_deb;
      if (r_sync2 == r_deb) begin
        r_deb_cnt <= '0;
      end else if (r_deb_cnt == DEB_LAST) begin
        r_deb     <= r_sync2;
        r_deb_cnt <= '0;
      end else begin
        r_deb_cnt <= r_deb_cnt + DW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetButton) begin
    if (!resetButton) begin
      r_state      <= S_IDLE;
      r_tick_cnt   <= '0;
      r_spin_cnt   <= '0;
      r_stag_cnt   <= '0;
      r_en         <= '0;
      r_led        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_roll_count <= '0;
    end else begin
      r_done     <= 1'b0;
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
      case (r_state)
        S_IDLE: begin
          if (r_press && (bus.dice_sel != 6'd0)) begin
            r_en       <= bus.dice_sel;
            r_led      <= 10'd1;
            r_busy     <= 1'b1;
            r_tick_cnt <= '0;
            r_spin_cnt <= '0;
            r_state    <= S_SPIN;
          end
        end
        S_SPIN: begin
          if (w_tick) begin
            r_led <= {r_led[8:0], r_led[9]};
            if (r_spin_cnt == SPIN_LAST) begin
              r_stag_cnt <= '0;
              r_state    <= S_SETTLE;
            end else begin
              r_spin_cnt <= r_spin_cnt + SW'(1);
            end
          end
        end
        S_SETTLE: begin
          if (r_en == 6'd0) begin
            r_done       <= 1'b1;
            r_roll_count <= r_roll_count + 8'd1;
            r_led        <= 10'h3FF;
            r_busy       <= 1'b0;
            r_state      <= S_DONE;
          end else if (w_tick) begin
            r_led <= {r_led[8:0], r_led[9]};
            if (r_stag_cnt == STAG_LAST) begin
              r_stag_cnt <= '0;
              r_en       <= r_en & (r_en - 6'd1);  // drop lowest set bit
            end else begin
              r_stag_cnt <= r_stag_cnt + GW'(1);
            end
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.en         = r_en;
  assign bus.LED        = r_led;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.roll_count = r_roll_count;
endmodule

// File: tb/tb_roll_sequencer.sv
// Directed bench for roll_sequencer: a schedule-level model predicts every
// output per cycle, and literal checks pin the key roll timings.
module tb_roll_sequencer;
  localparam int TD = 4;
  localparam int DB = 3;
  localparam int SP = 3;
  localparam int ST = 2;

  logic clk   = 1'b0;
  logic rst_b = 1'b0;
  roll_sequencer_if bus();

  roll_sequencer #(
    .TICK_DIV(TD), .DEBOUNCE_CYCLES(DB), .SPIN_TICKS(SP), .STAGGER_TICKS(ST)
  ) dut (
    .clk(clk), .resetButton(rst_b), .bus(bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int rel_edge = 0;
  int done_cnt = 0;
  int last_done_cyc = -1;
  logic chk_en = 1'b0;
  logic [5:0] en_acc = '0;

  // Model state: roll schedule (start edge, done edge) plus debounce view.
  logic bq[$];
  logic m_d;
  logic m_deb = 1'b1;
  int   m_run = 0;
  int   m_press_edge = -100;
  int   m_S = -100;
  int   m_D = -100;
  logic [5:0] m_sel = '0;
  logic [7:0] m_count = '0;
  logic [9:0] m_idle_led = '0;

  int x_t, x_k;
  logic [5:0] x_en;
  logic [9:0] x_led;
  logic x_busy, x_done;

  function automatic int popc(input logic [5:0] v);
    int n = 0;
    for (int i = 0; i < 6; i++) if (v[i]) n++;
    return n;
  endfunction

  function automatic logic [5:0] clear_low(input logic [5:0] v, input int k);
    logic [5:0] r = v;
    int left = k;
    for (int i = 0; i < 6; i++) begin
      if (r[i] && left > 0) begin
        r[i] = 1'b0;
        left--;
      end
    end
    return r;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      bq.delete();
      m_deb = 1'b1; m_run = 0; m_press_edge = -100;
      m_S = -100; m_D = -100; m_sel = '0; m_count = '0; m_idle_led = '0;
    end else begin
      cyc++;
      bq.push_back(bus.button);
      if (bq.size() > 3) void'(bq.pop_front());
      m_d = (bq.size() >= 3) ? bq[0] : 1'b1;
      if (m_d != m_deb) begin
        m_run++;
        if (m_run == DB) begin
          m_deb = m_d;
          m_run = 0;
          if (!m_deb) m_press_edge = cyc;
        end
      end else begin
        m_run = 0;
      end
      if (cyc == m_press_edge + 2 && cyc > m_D + 1 && bus.dice_sel != 6'd0) begin
        m_S   = cyc;
        m_sel = bus.dice_sel;
        m_D   = cyc + (SP + popc(m_sel) * ST) * TD + 1;
      end
      if (cyc == m_D) begin
        m_count++;
        m_idle_led = 10'h3FF;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      if (cyc >= m_S && cyc < m_D) begin
        x_t    = cyc - m_S;
        x_k    = (x_t < SP * TD) ? 0 : (x_t - SP * TD) / (ST * TD);
        x_en   = clear_low(m_sel, x_k);
        x_led  = 10'd1 << ((x_t / TD) % 10);
        x_busy = 1'b1;
        x_done = 1'b0;
      end else begin
        x_en   = '0;
        x_led  = (cyc == m_D) ? 10'h3FF : m_idle_led;
        x_busy = 1'b0;
        x_done = (cyc == m_D);
      end
      cmp("en", bus.en, x_en);
      cmp("LED", bus.LED, x_led);
      cmp("busy", bus.busy, x_busy);
      cmp("done", bus.done, x_done);
      cmp("roll_count", bus.roll_count, m_count);
      en_acc |= bus.en;
      if (bus.done) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
    end
  end

  task automatic wait_until(input int n);
    while (cyc < n) begin
      @(negedge clk);
      if (cyc + 1 >= rel_edge) bus.button = 1'b1;
    end
  endtask

  // Called at a negedge: button is low for exactly n rising edges from k.
  task automatic press(input int n, output int k);
    bus.button = 1'b0;
    k = cyc + 1;
    rel_edge = k + n;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int k, k2, s, d0;
    bus.button = 1'b1;
    bus.dice_sel = '0;
    chk_en = 1'b1;

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.button = i[0];
      bus.dice_sel = 6'(i * 9);
    end
    cmp("rst_en", bus.en, 0);
    cmp("rst_LED", bus.LED, 0);
    cmp("rst_busy", bus.busy, 0);
    cmp("rst_count", bus.roll_count, 0);
    @(negedge clk);
    bus.button = 1'b1;
    bus.dice_sel = '0;
    #2 rst_b = 1'b1;
    repeat (3) @(negedge clk);
    cmp("idle_after_rst_en", bus.en, 0);
    cmp("idle_after_rst_busy", bus.busy, 0);

    // basic roll, digits 0 and 2
    bus.dice_sel = 6'b000101;
    press(10, k);
    s = k + 6;
    wait_until(s);
    cmp("basic_en_start", bus.en, 6'b000101);
    cmp("basic_LED_start", bus.LED, 10'b1);
    cmp("basic_busy", bus.busy, 1);
    wait_until(s + 20);
    cmp("basic_en_first_settle", bus.en, 6'b000100);
    wait_until(s + 28);
    cmp("basic_en_all_settled", bus.en, 0);
    wait_until(s + 29);
    cmp("basic_done", bus.done, 1);
    cmp("basic_LED_done", bus.LED, 10'h3FF);
    cmp("basic_count", bus.roll_count, 1);
    wait_until(s + 32);
    cmp("basic_done_pulses", done_cnt, 1);

    // glitch then valid press
    bus.dice_sel = 6'b000001;
    d0 = done_cnt;
    press(2, k);
    wait_until(k + 20);
    cmp("glitch_en", bus.en, 0);
    cmp("glitch_busy", bus.busy, 0);
    press(8, k);
    s = k + 6;
    wait_until(s + 24);
    cmp("debounced_done_cnt", done_cnt, d0 + 1);
    cmp("debounced_done_cyc", last_done_cyc, s + 21);

    // press with nothing selected
    bus.dice_sel = 6'd0;
    d0 = done_cnt;
    press(4, k);
    wait_until(k + 40);
    cmp("empty_sel_done_cnt", done_cnt, d0);
    cmp("empty_sel_count", bus.roll_count, 2);

    // dice_sel change and second press during SPIN
    bus.dice_sel = 6'b000101;
    d0 = done_cnt;
    press(5, k);
    s = k + 6;
    en_acc = '0;
    wait_until(s + 2);
    bus.dice_sel = 6'h3F;
    wait_until(k + 9);
    press(5, k2);
    wait_until(s + 32);
    cmp("spin_change_en_bits", en_acc & 6'b111010, 0);
    cmp("spin_change_done_cnt", done_cnt, d0 + 1);
    cmp("spin_change_done_cyc", last_done_cyc, s + 29);

    // all six digits: chaser wrap and ordered settles
    press(4, k);
    s = k + 6;
    wait_until(s + 12);
    cmp("wrap_en_spin_end", bus.en, 6'h3F);
    cmp("wrap_LED_t3", bus.LED, 10'h008);
    wait_until(s + 20);
    cmp("wrap_en_s1", bus.en, 6'h3E);
    wait_until(s + 28);
    cmp("wrap_en_s2", bus.en, 6'h3C);
    wait_until(s + 36);
    cmp("wrap_en_s3", bus.en, 6'h38);
    cmp("wrap_LED_t9", bus.LED, 10'h200);
    wait_until(s + 40);
    cmp("wrap_LED_t10", bus.LED, 10'h001);
    wait_until(s + 44);
    cmp("wrap_en_s4", bus.en, 6'h30);
    wait_until(s + 52);
    cmp("wrap_en_s5", bus.en, 6'h20);
    wait_until(s + 60);
    cmp("wrap_en_s6", bus.en, 6'h00);
    wait_until(s + 61);
    cmp("wrap_done", bus.done, 1);
    cmp("wrap_count", bus.roll_count, 4);

    // reset during SETTLE
    wait_until(s + 64);
    press(4, k);
    s = k + 6;
    wait_until(s + 30);
    d0 = done_cnt;
    #2 rst_b = 1'b0;
    #1;
    cmp("midrst_en", bus.en, 0);
    cmp("midrst_LED", bus.LED, 0);
    cmp("midrst_busy", bus.busy, 0);
    cmp("midrst_count", bus.roll_count, 0);
    repeat (3) @(negedge clk);
    rst_b = 1'b1;
    repeat (40) @(negedge clk);
    cmp("midrst_no_done", done_cnt, d0);
    cmp("midrst_count_after", bus.roll_count, 0);

    // 256 rolls wrap the counter
    bus.dice_sel = 6'b000001;
    d0 = done_cnt;
    for (int i = 0; i < 256; i++) begin
      press(4, k);
      wait_until(k + 6 + 21 + 2);
      if (i == 254) cmp("count_255", bus.roll_count, 255);
    end
    cmp("count_wrap", bus.roll_count, 0);
    cmp("wrap_done_cnt", done_cnt, d0 + 256);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
